crc_append_ctrl: RTL and testbench

- Stream-side sequencer for crc_calc: forwards frames from a valid/ready input stream to a valid/ready output stream.
- Feeds every accepted data beat into an internal crc_calc instance.
- At end of frame, appends the finished CRC as CRC_SIZE/DATA_WIDTH extra beats, then re-initialises crc_calc through soft_reset_i for the next frame.
- Sits between a frame source (e.g. a packetiser) and the line/serialiser.

---
 rtl/crc_append_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_crc_append_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_append_ctrl.sv
// Frame sequencer that forwards a valid/ready stream, then appends the frame CRC as extra beats.
// Optional build macro CRC_APPEND_FRAME_CNT_EN adds the frame_cnt_o completed-frame counter.

module crc_calc #(
    parameter logic [63:0] POLY       = 64'h8005,
    parameter int unsigned CRC_SIZE   = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [63:0] INIT       = 64'h0000,
    parameter string       REF_IN     = "TRUE",
    parameter string       REF_OUT    = "TRUE",
    parameter logic [63:0] XOR_OUT    = 64'hffff
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  soft_reset_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CRC_SIZE-1:0]   crc_o
);

    localparam logic [CRC_SIZE-1:0] Poly   = POLY[CRC_SIZE-1:0];
    localparam logic [CRC_SIZE-1:0] Init   = INIT[CRC_SIZE-1:0];
    localparam logic [CRC_SIZE-1:0] XorOut = XOR_OUT[CRC_SIZE-1:0];
    localparam bit                  RefIn  = (REF_IN == "TRUE");
    localparam bit                  RefOut = (REF_OUT == "TRUE");

    // MSB-first shift register; reflected input is handled by feeding data LSB first.
    function automatic logic [CRC_SIZE-1:0] crc_step(input logic [CRC_SIZE-1:0] c,
                                                     input logic [DATA_WIDTH-1:0] d);
        logic [CRC_SIZE-1:0]   r;
        logic [DATA_WIDTH-1:0] dr;
        logic                  fb;
        r = c;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            dr[i] = d[DATA_WIDTH-1-i];
        end
        if (RefIn) begin
            dr = d;
        end
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            fb = r[CRC_SIZE-1] ^ dr[0];
            dr = dr >> 1;
            r  = (r << 1) ^ (fb ? Poly : '0);
        end
        return r;
    endfunction

    function automatic logic [CRC_SIZE-1:0] crc_final(input logic [CRC_SIZE-1:0] c);
        logic [CRC_SIZE-1:0] r;
        for (int i = 0; i < int'(CRC_SIZE); i++) begin
            r[i] = c[CRC_SIZE-1-i];
        end
        if (!RefOut) begin
            r = c;
        end
        return r ^ XorOut;
    endfunction

    logic [CRC_SIZE-1:0] state_q;
    logic [CRC_SIZE-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (soft_reset_i) begin
            state_d = Init;
        end else if (valid_i) begin
            state_d = crc_step(state_q, data_i);
        end
    end

    // crc_o is registered from the next state so it is final the cycle after the last beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Init;
            crc_o   <= crc_final(Init);
        end else begin
            state_q <= state_d;
            crc_o   <= crc_final(state_d);
        end
    end

endmodule

module crc_append_ctrl #(
    parameter logic [63:0] POLY       = 64'h8005,
    parameter int unsigned CRC_SIZE   = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [63:0] INIT       = 64'h0000,
    parameter string       REF_IN     = "TRUE",
    parameter string       REF_OUT    = "TRUE",
    parameter logic [63:0] XOR_OUT    = 64'hffff
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o
`ifdef CRC_APPEND_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt_o
`endif
);

    localparam int unsigned     NumWords = CRC_SIZE / DATA_WIDTH;
    localparam int unsigned     IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumWords - 1);

    typedef enum logic [1:0] {
        StPass,
        StWait,
        StAppend,
        StClear
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CRC_SIZE-1:0]   crc_q, crc_d;
    logic                  busy_q, busy_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic                  out_free;
    logic                  calc_valid;
    logic                  calc_soft_reset;
    logic [CRC_SIZE-1:0]   calc_crc;

    crc_calc #(
        .POLY       (POLY),
        .CRC_SIZE   (CRC_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT       (INIT),
        .REF_IN     (REF_IN),
        .REF_OUT    (REF_OUT),
        .XOR_OUT    (XOR_OUT)
    ) u_crc_calc (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .soft_reset_i (calc_soft_reset),
        .valid_i      (calc_valid),
        .data_i       (s_data_i),
        .crc_o        (calc_crc)
    );

    assign out_free = ~m_valid_q | m_ready_i;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        crc_d           = crc_q;
        busy_d          = busy_q;
        m_valid_d       = m_valid_q & ~m_ready_i;
        m_data_d        = m_data_q;
        m_last_d        = m_last_q;
        s_ready_o       = 1'b0;
        calc_valid      = 1'b0;
        calc_soft_reset = 1'b0;

        unique case (state_q)
            StPass: begin
                s_ready_o = out_free;
                if (s_valid_i && out_free) begin
                    m_valid_d  = 1'b1;
                    m_data_d   = s_data_i;
                    m_last_d   = 1'b0;
                    calc_valid = 1'b1;
                    busy_d     = 1'b1;
                    if (s_last_i) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                crc_d   = calc_crc;
                idx_d   = '0;
                state_d = StAppend;
            end
            StAppend: begin
                // crc_q shifts down one word per load so word 0 is always the next to send.
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = crc_q[DATA_WIDTH-1:0];
                    m_last_d  = (idx_q == LastIdx);
                    crc_d     = crc_q >> DATA_WIDTH;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StClear;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StClear: begin
                calc_soft_reset = 1'b1;
                busy_d          = 1'b0;
                state_d         = StPass;
            end
            default: begin
                state_d = StPass;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StPass;
            idx_q     <= '0;
            crc_q     <= '0;
            busy_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            crc_q     <= crc_d;
            busy_q    <= busy_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_last_o  = m_last_q;
    assign busy_o    = busy_q;

`ifdef CRC_APPEND_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= 16'h0000;
        end else if (m_valid_q && m_ready_i && m_last_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_crc_append_ctrl.sv
// Directed bench for crc_append_ctrl with CRC-16/MAXIM defaults.
// Exercises the frame counter as well when CRC_APPEND_FRAME_CNT_EN is defined.

module tb_crc_append_ctrl;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [8:0] beat_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
`ifdef CRC_APPEND_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    beat_q_t cap_q;
    logic    rand_ready = 1'b0;
    logic    hold_pend  = 1'b0;
    logic [8:0] hold_beat;

    crc_append_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_data_o    (m_data),
        .m_last_o    (m_last),
        .busy_o      (busy)
`ifdef CRC_APPEND_FRAME_CNT_EN
        ,
        .frame_cnt_o (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reflected-table-free reference for CRC-16/MAXIM.
    function automatic logic [15:0] crc_maxim(input byte_q_t b);
        logic [15:0] c;
        c = 16'h0000;
        foreach (b[i]) begin
            c = c ^ {8'h00, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 16'ha001) : (c >> 1);
            end
        end
        return c ^ 16'hffff;
    endfunction

    function automatic beat_q_t make_exp(input byte_q_t b, input logic [15:0] crc);
        beat_q_t q;
        foreach (b[i]) q.push_back({1'b0, b[i]});
        q.push_back({1'b0, crc[7:0]});
        q.push_back({1'b1, crc[15:8]});
        return q;
    endfunction

    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_beat", 32'({m_last, m_data}), 32'(hold_beat));
            end
            if (m_valid && m_ready) cap_q.push_back({m_last, m_data});
            hold_pend = m_valid && !m_ready;
            hold_beat = {m_last, m_data};
        end
    end

    // Called and returns at posedge+1.
    task automatic send_frame(input byte_q_t b, input bit with_last, output int first_stall);
        first_stall = 0;
        for (int i = 0; i < b.size(); i++) begin
            int n = 0;
            s_valid = 1'b1;
            s_data  = b[i];
            s_last  = with_last && (i == b.size() - 1);
            @(negedge clk);
            while (!s_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("send_ready", 32'(s_ready), 32'd1);
            if (i == 0) first_stall = n;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic expect_beats(input string tag, input beat_q_t exp);
        int n = 0;
        while (cap_q.size() < exp.size() && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        check({tag, "_count"}, 32'(cap_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < cap_q.size(); i++) begin
            check($sformatf("%s_beat%0d", tag, i), 32'(cap_q[i]), 32'(exp[i]));
        end
        cap_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_m_last"}, 32'(m_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cap_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t f9;
        byte_q_t f0;
        byte_q_t f4;
        beat_q_t e;
        int      stall;

        f9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        f0 = '{8'h00};
        f4 = '{8'h31, 8'h32, 8'h33, 8'h34};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        #1;
        check_reset_outputs("rst0");
        repeat (2) @(negedge clk);
        check_reset_outputs("rst1");
        check("rst_s_ready", 32'(s_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single 9-byte frame, CRC words c2 then 44.
        send_frame(f9, 1'b1, stall);
        check("f1_busy", 32'(busy), 32'd1);
        check("f1_stall", 32'(stall), 32'd0);
        expect_beats("f1", make_exp(f9, 16'h44c2));
        check("f1_idle_busy", 32'(busy), 32'd0);

        // Back-to-back frames: second starts after WAIT + 2 APPEND + CLEAR.
        e = make_exp(f9, 16'h44c2);
        foreach (f9[i]) e.push_back({1'b0, f9[i]});
        e.push_back({1'b0, 8'hc2});
        e.push_back({1'b1, 8'h44});
        send_frame(f9, 1'b1, stall);
        send_frame(f9, 1'b1, stall);
        check("b2b_stall", 32'(stall), 32'd4);
        expect_beats("b2b", e);

        // Single-beat frame.
        send_frame(f0, 1'b1, stall);
        expect_beats("one", make_exp(f0, crc_maxim(f0)));

        // Random downstream backpressure.
        rand_ready = 1'b1;
        send_frame(f9, 1'b1, stall);
        expect_beats("bp", make_exp(f9, 16'h44c2));
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-frame.
        send_frame(f4, 1'b0, stall);
        check("abort_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        @(negedge clk);
        check_reset_outputs("arst_hold");
        rst = 1'b0;
        cap_q.delete();
        @(posedge clk);
        #1;
        repeat (6) @(negedge clk);
        check("abort_no_crc", 32'(cap_q.size()), 32'd0);
        @(posedge clk);
        #1;
        send_frame(f9, 1'b1, stall);
        expect_beats("post_rst", make_exp(f9, 16'h44c2));

`ifdef CRC_APPEND_FRAME_CNT_EN
        apply_reset();
        check("fc_reset", 32'(frame_cnt), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            send_frame(f9, 1'b1, stall);
            expect_beats($sformatf("fc%0d", k), make_exp(f9, 16'h44c2));
            check($sformatf("fc_cnt%0d", k), 32'(frame_cnt), 32'(k));
        end
        force dut.frame_cnt_q = 16'hffff;
        #1;
        release dut.frame_cnt_q;
        @(posedge clk);
        #1;
        send_frame(f0, 1'b1, stall);
        expect_beats("fc_wrap_frame", make_exp(f0, crc_maxim(f0)));
        check("fc_wrap", 32'(frame_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
